// File: rtl/offset_move_scheduler.sv
// Window-position controller: latches direction requests and applies at most one
// step-move per frame, committing all four bounds together so they never disagree.
module offset_move_scheduler #(
  parameter int unsigned HDR    = 640,
  parameter int unsigned VDR    = 480,
  parameter int unsigned WIN_W  = 64,
  parameter int unsigned WIN_H  = 64,
  parameter int unsigned STEP_H = 64,
  parameter int unsigned STEP_V = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dirReq,
  input  logic       frameStart,
  output logic [9:0] posHorStart,
  output logic [9:0] posHorEnd,
  output logic [9:0] posVerStart,
  output logic [9:0] posVerEnd,
  output logic       horWrap,
  output logic       verWrap,
  output logic       busy,
  output logic       moveDone
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam logic [10:0] HRES  = 11'(HDR);
  localparam logic [10:0] VRES  = 11'(VDR);
  localparam logic [10:0] SH    = 11'(STEP_H);
  localparam logic [10:0] SV    = 11'(STEP_V);
  localparam logic [10:0] WW_M1 = 11'(WIN_W - 1);
  localparam logic [10:0] WH_M1 = 11'(WIN_H - 1);

  localparam logic [9:0] HOR_START_RST = 10'((HDR - WIN_W) / 2);
  localparam logic [9:0] HOR_END_RST   = 10'((HDR - WIN_W) / 2 + WIN_W - 1);
  localparam logic [9:0] VER_START_RST = 10'((VDR - WIN_H) / 2);
  localparam logic [9:0] VER_END_RST   = 10'((VDR - WIN_H) / 2 + WIN_H - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] pending_q, pending_d, pending_clr;
  logic [3:0] req_q, rise;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [9:0] hor_nxt_q, hor_nxt_d, ver_nxt_q, ver_nxt_d;
  logic [1:0] sel_idx, cand;
  logic       sel_found;
  logic [10:0] s11, t11, hor_end_sum, ver_end_sum;
  logic [9:0]  hor_end, ver_end;

  assign rise = dirReq & ~req_q;
  assign busy = (state_q != IDLE);

  // First pending bit at or after the round-robin pointer, cyclic Up..Right.
  always_comb begin
    sel_idx   = rr_ptr_q;
    sel_found = 1'b0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!sel_found && pending_q[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_clr = 4'b0000;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    hor_nxt_d   = hor_nxt_q;
    ver_nxt_d   = ver_nxt_q;
    s11         = 11'd0;
    t11         = 11'd0;
    unique case (state_q)
      IDLE: begin
        if (frameStart) begin
          if (pending_q[3] && pending_q[2]) pending_clr[3:2] = 2'b11;
          if (pending_q[1] && pending_q[0]) pending_clr[1:0] = 2'b11;
          if ((pending_q & ~pending_clr) != 4'b0000) state_d = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          pending_clr[sel_idx] = 1'b1;
          rr_ptr_d             = sel_idx + 2'd1;
          grant_d              = sel_idx;
          state_d              = UPDATE;
        end else begin
          state_d = IDLE;
        end
      end
      UPDATE: begin
        hor_nxt_d = posHorStart;
        ver_nxt_d = posVerStart;
        unique case (grant_q)
          2'd0: begin
            s11 = {1'b0, posVerStart};
            t11 = (s11 >= SV) ? s11 - SV : s11 + VRES - SV;
            ver_nxt_d = t11[9:0];
          end
          2'd1: begin
            s11 = {1'b0, posVerStart};
            t11 = (s11 + SV >= VRES) ? s11 + SV - VRES : s11 + SV;
            ver_nxt_d = t11[9:0];
          end
          2'd2: begin
            s11 = {1'b0, posHorStart};
            t11 = (s11 >= SH) ? s11 - SH : s11 + HRES - SH;
            hor_nxt_d = t11[9:0];
          end
          default: begin
            s11 = {1'b0, posHorStart};
            t11 = (s11 + SH >= HRES) ? s11 + SH - HRES : s11 + SH;
            hor_nxt_d = t11[9:0];
          end
        endcase
        state_d = COMMIT;
      end
      default: state_d = IDLE;
    endcase
    // A new rising edge wins over a same-cycle clear.
    pending_d = (pending_q & ~pending_clr) | rise;
  end

  always_comb begin
    hor_end_sum = {1'b0, hor_nxt_q} + WW_M1;
    ver_end_sum = {1'b0, ver_nxt_q} + WH_M1;
    hor_end     = (hor_end_sum >= HRES) ? 10'(hor_end_sum - HRES) : hor_end_sum[9:0];
    ver_end     = (ver_end_sum >= VRES) ? 10'(ver_end_sum - VRES) : ver_end_sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= 4'b0000;
      req_q       <= 4'b0000;
      rr_ptr_q    <= 2'd0;
      grant_q     <= 2'd0;
      hor_nxt_q   <= HOR_START_RST;
      ver_nxt_q   <= VER_START_RST;
      posHorStart <= HOR_START_RST;
      posHorEnd   <= HOR_END_RST;
      posVerStart <= VER_START_RST;
      posVerEnd   <= VER_END_RST;
      horWrap     <= 1'b0;
      verWrap     <= 1'b0;
      moveDone    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= dirReq;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      hor_nxt_q <= hor_nxt_d;
      ver_nxt_q <= ver_nxt_d;
      moveDone  <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        posHorStart <= hor_nxt_q;
        posHorEnd   <= hor_end;
        posVerStart <= ver_nxt_q;
        posVerEnd   <= ver_end;
        horWrap     <= (hor_end < hor_nxt_q);
        verWrap     <= (ver_end < ver_nxt_q);
      end
    end
  end

endmodule

// File: tb/tb_offset_move_scheduler.sv
// Directed bench for offset_move_scheduler: hand-computed bounds after each move.
module tb_offset_move_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dirReq;
  logic       frameStart;
  logic [9:0] posHorStart, posHorEnd, posVerStart, posVerEnd;
  logic       horWrap, verWrap, busy, moveDone;

  int compared   = 0;
  int mismatched = 0;

  offset_move_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .dirReq      (dirReq),
    .frameStart  (frameStart),
    .posHorStart (posHorStart),
    .posHorEnd   (posHorEnd),
    .posVerStart (posVerStart),
    .posVerEnd   (posVerEnd),
    .horWrap     (horWrap),
    .verWrap     (verWrap),
    .busy        (busy),
    .moveDone    (moveDone)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bounds(input string tag, input int hs, input int he, input int vs,
                            input int ve, input int hw, input int vw);
    chk({tag, ".hs"}, 32'(posHorStart), 32'(hs));
    chk({tag, ".he"}, 32'(posHorEnd), 32'(he));
    chk({tag, ".vs"}, 32'(posVerStart), 32'(vs));
    chk({tag, ".ve"}, 32'(posVerEnd), 32'(ve));
    chk({tag, ".hw"}, 32'(horWrap), 32'(hw));
    chk({tag, ".vw"}, 32'(verWrap), 32'(vw));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic pulse_dir(input int i);
    dirReq[i] = 1'b1;
    step();
    dirReq[i] = 1'b0;
    step();
  endtask

  // frameStart sampled at edge k; results are visible after edge k+3.
  task automatic frame(input string tag, input int exp_done);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    step();
    step();
    step();
    chk({tag, ".done"}, 32'(moveDone), 32'(exp_done));
  endtask

  initial begin
    reset      = 1'b0;
    dirReq     = 4'b0000;
    frameStart = 1'b0;

    // 1: reset state
    do_reset();
    chk_bounds("rst", 288, 351, 208, 271, 0, 0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(moveDone), 32'd0);

    // 2: single Up move, latency and one-cycle pulse
    pulse_dir(0);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    chk("up1.busy_sel", 32'(busy), 32'd1);
    chk("up1.done_early", 32'(moveDone), 32'd0);
    step();
    step();
    chk("up1.done_n2", 32'(moveDone), 32'd0);
    step();
    chk("up1.done", 32'(moveDone), 32'd1);
    chk_bounds("up1", 288, 351, 144, 207, 0, 0);
    step();
    chk("up1.done_off", 32'(moveDone), 32'd0);
    chk("up1.busy_off", 32'(busy), 32'd0);

    // 3: four Ups from reset with wrap, then Down
    do_reset();
    pulse_dir(0); frame("u1", 1); chk("u1.vs", 32'(posVerStart), 32'd144);
    pulse_dir(0); frame("u2", 1); chk("u2.vs", 32'(posVerStart), 32'd80);
    pulse_dir(0); frame("u3", 1); chk("u3.vs", 32'(posVerStart), 32'd16);
    pulse_dir(0); frame("u4", 1); chk_bounds("u4", 288, 351, 432, 15, 0, 1);
    pulse_dir(1); frame("d1", 1); chk_bounds("d1", 288, 351, 16, 79, 0, 0);

    // 4: opposing cancel, then Up+Left arbitration across two frames
    do_reset();
    pulse_dir(2);
    pulse_dir(3);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    chk("cancel.busy", 32'(busy), 32'd0);
    step();
    step();
    chk("cancel.done", 32'(moveDone), 32'd0);
    chk_bounds("cancel", 288, 351, 208, 271, 0, 0);
    pulse_dir(0);
    pulse_dir(2);
    frame("ul1", 1); chk_bounds("ul1", 288, 351, 144, 207, 0, 0);
    step();
    frame("ul2", 1); chk_bounds("ul2", 224, 287, 144, 207, 0, 0);
    step();
    frame("ul3", 0);

    // 5: repeated Up edges collapse; edge during busy is kept
    do_reset();
    pulse_dir(0);
    pulse_dir(0);
    pulse_dir(0);
    frame("rep1", 1); chk("rep1.vs", 32'(posVerStart), 32'd144);
    step();
    frame("rep2", 0); chk("rep2.vs", 32'(posVerStart), 32'd144);
    pulse_dir(0);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    dirReq[0]  = 1'b1;
    step();
    dirReq[0]  = 1'b0;
    step();
    step();
    chk("busy1.done", 32'(moveDone), 32'd1);
    chk("busy1.vs", 32'(posVerStart), 32'd80);
    step();
    frame("busy2", 1); chk_bounds("busy2", 288, 351, 16, 79, 0, 0);

    // 6: reset during UPDATE discards the move
    do_reset();
    pulse_dir(1);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_bounds("mid", 288, 351, 208, 271, 0, 0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(moveDone), 32'd0);
    step();
    chk("mid.done2", 32'(moveDone), 32'd0);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    chk("mid.pend_busy", 32'(busy), 32'd0);
    step();
    step();
    chk("mid.pend_done", 32'(moveDone), 32'd0);
    chk("mid.vs", 32'(posVerStart), 32'd208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
